// File: rtl/pixel_unpacker.sv
// Unpacks 24-bpp video packed four pixels per three 32-bit AXI-Stream words into one RGB pixel
// per beat, tagging each pixel with its x/y position, sof and eol. Framing problems on the input
// stream are recorded in sticky error bits, and completed frames are counted.
module pixel_unpacker #(
   parameter int unsigned X_SIZE = 640,
   parameter int unsigned Y_SIZE = 480
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] in_stream_tdata,
   input  logic [3:0]  in_stream_tkeep,
   input  logic        in_stream_tlast,
   input  logic        in_stream_tuser,
   input  logic        in_stream_tvalid,
   output logic        in_stream_tready,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic        sof,
   output logic        eol,
   output logic        pix_valid,
   input  logic        pix_ready,
   input  logic        err_clr,
   output logic        sof_err,
   output logic        eol_err,
   output logic        keep_err,
   output logic [15:0] frame_count
);

   localparam logic [9:0] XLast = 10'(X_SIZE - 1);
   localparam logic [9:0] XPen  = 10'(X_SIZE - 2);
   localparam logic [8:0] YLast = 9'(Y_SIZE - 1);

   typedef enum logic [1:0] {StPh0, StPh1, StPh2} phase_e;

   phase_e      phase_q, phase_d, eff_phase;
   logic [15:0] residue_q, residue_d;
   logic [23:0] hold_q, hold_d;
   logic        p3_pend_q;
   logic        pix_valid_q;
   logic [23:0] pix_q, word_pix;
   logic [9:0]  x_q, pos_x_q, base_x, step_x;
   logic [8:0]  y_q, pos_y_q, base_y, step_y;
   logic        sof_err_q, eol_err_q, keep_err_q;
   logic [15:0] frame_count_q;
   logic        word_acc, pix_acc, resync, at_start, eol_exp;
   logic        sof_set, eol_set, keep_set;

   // No new word while p3 still waits in the hold register.
   assign in_stream_tready = (!pix_valid_q | pix_ready) & !p3_pend_q;
   assign word_acc         = in_stream_tvalid & in_stream_tready;
   assign pix_acc          = pix_valid_q & pix_ready;
   assign resync           = word_acc & in_stream_tuser;
   // A tuser word is always treated as the first word of a group, whatever the phase.
   assign eff_phase        = in_stream_tuser ? StPh0 : phase_q;
   assign at_start         = (phase_q == StPh0) && (pos_x_q == '0) && (pos_y_q == '0);

   // Phase register: tracks which word of the 3-word group comes next.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         phase_q <= StPh0;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Phase advances once per accepted word.
   always_comb begin
      phase_d = phase_q;
      if (word_acc) begin
         case (eff_phase)
            StPh0:   phase_d = StPh1;
            StPh1:   phase_d = StPh2;
            default: phase_d = StPh0;
         endcase
      end
   end

   // Per-phase byte steering: pixel emitted by this word and leftover bytes kept for the next.
   always_comb begin
      word_pix  = '0;
      residue_d = residue_q;
      hold_d    = hold_q;
      if (word_acc) begin
         case (eff_phase)
            StPh0: begin
               word_pix  = in_stream_tdata[23:0];
               residue_d = {8'h00, in_stream_tdata[31:24]};
            end
            StPh1: begin
               word_pix  = {in_stream_tdata[15:0], residue_q[7:0]};
               residue_d = in_stream_tdata[31:16];
            end
            default: begin
               word_pix  = {in_stream_tdata[7:0], residue_q};
               residue_d = '0;
               hold_d    = in_stream_tdata[31:8];
            end
         endcase
      end
   end

   // Position of the pixel being loaded now, and the position that follows it.
   always_comb begin
      base_x = resync ? '0 : pos_x_q;
      base_y = resync ? '0 : pos_y_q;
      step_x = base_x + 10'd1;
      step_y = base_y;
      if (base_x == XLast) begin
         step_x = '0;
         step_y = (base_y == YLast) ? '0 : base_y + 9'd1;
      end
   end

   // Framing checks on each accepted word; a PH2 word carries p2 at pos_x_q and p3 just after it.
   always_comb begin
      eol_exp  = (eff_phase == StPh2) && (pos_x_q == XPen);
      sof_set  = word_acc & (in_stream_tuser != at_start);
      eol_set  = word_acc & (in_stream_tlast != eol_exp);
      keep_set = word_acc & (in_stream_tkeep != 4'hF);
   end

   // Residue and hold storage for bytes that straddle word boundaries.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         residue_q <= '0;
         hold_q    <= '0;
      end else begin
         residue_q <= residue_d;
         hold_q    <= hold_d;
      end
   end

   // Output pixel register: p3 from the hold register takes priority, then a fresh word.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pix_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         p3_pend_q   <= 1'b0;
         pix_valid_q <= 1'b0;
      end else if (pix_acc && p3_pend_q) begin
         pix_q       <= hold_q;
         x_q         <= base_x;
         y_q         <= base_y;
         pos_x_q     <= step_x;
         pos_y_q     <= step_y;
         p3_pend_q   <= 1'b0;
         pix_valid_q <= 1'b1;
      end else if (word_acc) begin
         pix_q       <= word_pix;
         x_q         <= base_x;
         y_q         <= base_y;
         pos_x_q     <= step_x;
         pos_y_q     <= step_y;
         p3_pend_q   <= (eff_phase == StPh2);
         pix_valid_q <= 1'b1;
      end else if (pix_acc) begin
         pix_valid_q <= 1'b0;
      end
   end

   // Sticky error bits; a new error wins over a simultaneous clear.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sof_err_q  <= 1'b0;
         eol_err_q  <= 1'b0;
         keep_err_q <= 1'b0;
      end else begin
         if (sof_set)      sof_err_q  <= 1'b1;
         else if (err_clr) sof_err_q  <= 1'b0;
         if (eol_set)      eol_err_q  <= 1'b1;
         else if (err_clr) eol_err_q  <= 1'b0;
         if (keep_set)     keep_err_q <= 1'b1;
         else if (err_clr) keep_err_q <= 1'b0;
      end
   end

   // Frame counter bumps when the last pixel of a frame is taken downstream.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         frame_count_q <= '0;
      end else if (pix_acc && (x_q == XLast) && (y_q == YLast)) begin
         frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign r           = pix_q[23:16];
   assign g           = pix_q[15:8];
   assign b           = pix_q[7:0];
   assign x           = x_q;
   assign y           = y_q;
   assign sof         = (x_q == '0) && (y_q == '0);
   assign eol         = (x_q == XLast);
   assign pix_valid   = pix_valid_q;
   assign sof_err     = sof_err_q;
   assign eol_err     = eol_err_q;
   assign keep_err    = keep_err_q;
   assign frame_count = frame_count_q;

endmodule
